smvm_batch_scheduler: RTL and testbench
=======================================

# smvm_batch_scheduler

Front-end controller for the sparse matrix-vector multiply datapath. It parses the serial frame stream into header, dense vector, then (value, column, IPV) nonzero pairs. It writes the vector into the vector store and packs nonzeros into K-wide batches for the multiplier/reduction pipeline, using a valid/ready handshake on both sides. It also checks frame consistency and flags errors.

## Interface
- K, 4, nonzero slots per batch
- VW, 8, value width (signed)
- MAXC, 128, maximum vector length
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  scheduler accepts word; transfer = in_valid & in_ready
- val_in  in  VW  header count / vector element / nonzero value / column index (low 7 bits)
- ipv_in  in  1  on a nonzero value word: 1 = last nonzero of its row
- vec_we  out  1  vector store write strobe
- vec_addr  out  7  vector store address
- vec_data  out  VW  vector element
- batch_valid  out  1  batch register holds a batch
- batch_ready  in  1  datapath accepts batch; accept = batch_valid & batch_ready
- batch_val  out  VW*K  slot values, slot 0 in MSBs
- batch_col  out  7*K  slot column indices, slot 0 in MSBs
- batch_ipv  out  K  slot row-end bits, slot 0 = bit K-1
- batch_last  out  1  final batch of the frame
- frame_done  out  1  one-cycle pulse when the last batch is accepted
- err  out  1  sticky frame error, cleared by the next accepted rows header

## Operation
- States: IDLE, HDR_COL, VEC, NZ_VAL, NZ_IDX, FLUSH, DONE.
- IDLE: a word with val_in != 0 sets rows = val_in, clears err and rows_seen, and moves to HDR_COL. Words with val_in == 0 are accepted and dropped.
- HDR_COL: sets cols = val_in. If cols == 0 or cols > MAXC, set err and return to IDLE. Otherwise clear vec_cnt and move to VEC.
- VEC: each transfer writes element vec_cnt. After element cols-1, go to NZ_VAL.
- NZ_VAL: if val_in != 0, latch the value and ipv_in into slot[slot_cnt], add ipv_in to rows_seen, and go to NZ_IDX. If val_in == 0 (terminator), go to FLUSH.
- NZ_IDX: latch val_in[6:0] into the slot's column. If the column is >= cols, set err and replace the slot's value and column with 0; IPV is kept. slot_cnt wraps K-1 -> 0. When slot K-1 fills, the batch is complete. Return to NZ_VAL.
- Completed batch handling:
  - It moves to the batch register when the register is empty or being accepted in the same cycle.
  - Otherwise asm_full=1 and in_ready=0 until it moves.
- FLUSH: in_ready=0. When the batch register is free, load the partial batch with slot_cnt..K-1 padded (val 0, col 0, ipv 0) and batch_last=1. If slot_cnt == 0, the load is an all-padding batch with batch_last=1. Then go to DONE.
- DONE: in_ready=0. When the batch_last batch is accepted, pulse frame_done. If rows_seen != rows, set err. Return to IDLE.
- rows_seen is 8 bits and saturates at 255.
- in_ready = 1 in IDLE, HDR_COL, VEC, NZ_VAL and NZ_IDX, except while asm_full.

## Timing
- Reset values: in_ready 0 during rst; state IDLE; vec_we, batch_valid, batch_last, frame_done, err all 0; all counters, slots and the batch register 0. Any buffered batch is discarded.
- Reset mid-frame aborts the frame. The first cycle after rst deasserts is IDLE with in_ready=1.
- Vector write is registered: a VEC transfer at cycle t gives vec_we=1 with addr/data at t+1.
- Batch latency: the IDX transfer of slot K-1 at t gives batch_valid=1 at t+1 if the register was free or accepted at t.
- The batch register holds all fields stable while batch_valid & ~batch_ready.
- Accept and load in the same cycle is allowed, giving back-to-back batches.
- frame_done is asserted in the cycle after the last accept. A new rows header is accepted in that same cycle.
- err updates one cycle after the offending transfer, or with frame_done for the row-count check.

## Test plan
- rows=2, cols=4, vec {1,2,3,4}, nonzeros (5,c0,0)(6,c3,1)(7,c1,0)(8,c2,1), then 0 -> vec_we addr 0..3, data 1..4. One batch val {5,6,7,8}, col {0,3,1,2}, ipv 0101, batch_last=0. Then an all-padding batch with batch_last=1, frame_done, err=0.
- Same header, 3 nonzeros (ipv 0,0,1), rows=1, then 0 -> one batch with slot 3 padded, batch_last=1, ipv 0010, err=0.
- Hold batch_ready=0 while 8 nonzeros arrive -> first batch held stable. in_ready drops after the second batch completes and rises one cycle after batch_ready=1. No data is lost.
- Column index 9 with cols=4 -> that slot has val 0, col 0, ipv kept, err=1 one cycle later. err clears on the next rows header.
- cols=0 header -> err=1 and return to IDLE. Separately, rows=3 with only 2 ipv bits set -> err=1 with frame_done.
- Assert rst mid-VEC, then send a fresh frame -> no stale vec_we or batch, and the new frame completes correctly.

Source files
------------

// File: rtl/smvm_batch_scheduler_if.sv
// Stream, vector-store and batch handshake bundle for the SMVM front end.
interface smvm_batch_scheduler_if #(
  parameter int K  = 4,
  parameter int VW = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [VW-1:0]   val_in;
  logic            ipv_in;
  logic            vec_we;
  logic [6:0]      vec_addr;
  logic [VW-1:0]   vec_data;
  logic            batch_valid;
  logic            batch_ready;
  logic [VW*K-1:0] batch_val;
  logic [7*K-1:0]  batch_col;
  logic [K-1:0]    batch_ipv;
  logic            batch_last;
  logic            frame_done;
  logic            err;

  modport master (
    input  in_valid, val_in, ipv_in,
    input  batch_ready,
    output in_ready,
    output vec_we, vec_addr, vec_data,
    output batch_valid, batch_val,
    output batch_col, batch_ipv,
    output batch_last, frame_done, err
  );

  modport slave (
    output in_valid, val_in, ipv_in,
    output batch_ready,
    input  in_ready,
    input  vec_we, vec_addr, vec_data,
    input  batch_valid, batch_val,
    input  batch_col, batch_ipv,
    input  batch_last, frame_done, err
  );
endinterface

// File: rtl/smvm_batch_scheduler.sv
// Frame parser and K-wide nonzero batcher feeding the SMVM pipeline.
module smvm_batch_scheduler #(
  parameter int K    = 4,
  parameter int VW   = 8,
  parameter int MAXC = 128
) (
  input logic clk,
  input logic rst,
  smvm_batch_scheduler_if.master bus
);
  localparam int SW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [2:0] {
    IDLE, HDR_COL, VEC, NZ_VAL,
    NZ_IDX, FLUSH, DONE
  } state_t;

  state_t          state;
  logic [VW-1:0]   rows;
  logic [VW-1:0]   cols;
  logic [VW-1:0]   vec_cnt;
  logic [7:0]      rows_seen;
  logic [SW-1:0]   slot_cnt;
  logic [VW-1:0]   asm_val [K];
  logic [6:0]      asm_col [K];
  logic [K-1:0]    asm_ipv;
  logic            asm_full;

  logic            xfer;
  logic            bfree;
  logic            last_slot;
  logic            col_bad;
  logic            load;
  logic [6:0]      idx_col;
  logic [VW-1:0]   idx_val;
  logic [VW*K-1:0] pk_val;
  logic [7*K-1:0]  pk_col;
  logic [K-1:0]    pk_ipv;

  assign bus.in_ready = !rst && !asm_full &&
    (state inside {IDLE, HDR_COL, VEC,
                   NZ_VAL, NZ_IDX});
  assign xfer      = bus.in_valid && bus.in_ready;
  assign bfree     = !bus.batch_valid ||
                     bus.batch_ready;
  assign last_slot = slot_cnt == SW'(K - 1);
  assign col_bad   = VW'(bus.val_in[6:0]) >= cols;
  assign idx_col   = col_bad ? '0 : bus.val_in[6:0];
  assign idx_val   = col_bad ? '0 : asm_val[slot_cnt];

  // One load source per cycle: parked batch, fresh batch, or flush.
  assign load = (asm_full && bfree) ||
                (state == FLUSH && bfree) ||
                (xfer && state == NZ_IDX &&
                 last_slot && bfree);

  always_comb begin
    pk_val = '0;
    pk_col = '0;
    pk_ipv = '0;
    for (int i = 0; i < K; i++) begin
      if (!(state == FLUSH && i >= int'(slot_cnt))) begin
        pk_val[(K-1-i)*VW +: VW] =
          (state == NZ_IDX && i == int'(slot_cnt)) ?
          idx_val : asm_val[i];
        pk_col[(K-1-i)*7 +: 7] =
          (state == NZ_IDX && i == int'(slot_cnt)) ?
          idx_col : asm_col[i];
        pk_ipv[K-1-i] = asm_ipv[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      rows            <= '0;
      cols            <= '0;
      vec_cnt         <= '0;
      rows_seen       <= '0;
      slot_cnt        <= '0;
      asm_ipv         <= '0;
      asm_full        <= 1'b0;
      for (int i = 0; i < K; i++) begin
        asm_val[i] <= '0;
        asm_col[i] <= '0;
      end
      bus.vec_we      <= 1'b0;
      bus.vec_addr    <= '0;
      bus.vec_data    <= '0;
      bus.batch_valid <= 1'b0;
      bus.batch_val   <= '0;
      bus.batch_col   <= '0;
      bus.batch_ipv   <= '0;
      bus.batch_last  <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.err         <= 1'b0;
    end else begin
      bus.vec_we     <= 1'b0;
      bus.frame_done <= 1'b0;
      if (load) begin
        bus.batch_valid <= 1'b1;
        bus.batch_val   <= pk_val;
        bus.batch_col   <= pk_col;
        bus.batch_ipv   <= pk_ipv;
        bus.batch_last  <= state == FLUSH;
      end else if (bus.batch_valid && bus.batch_ready) begin
        bus.batch_valid <= 1'b0;
        bus.batch_last  <= 1'b0;
      end
      if (asm_full && bfree)
        asm_full <= 1'b0;
      unique case (state)
        IDLE:
          if (xfer && bus.val_in != '0) begin
            rows      <= bus.val_in;
            rows_seen <= '0;
            bus.err   <= 1'b0;
            state     <= HDR_COL;
          end
        HDR_COL:
          if (xfer) begin
            cols <= bus.val_in;
            if (bus.val_in == '0 ||
                bus.val_in > VW'(MAXC)) begin
              bus.err <= 1'b1;
              state   <= IDLE;
            end else begin
              vec_cnt <= '0;
              state   <= VEC;
            end
          end
        VEC:
          if (xfer) begin
            bus.vec_we   <= 1'b1;
            bus.vec_addr <= vec_cnt[6:0];
            bus.vec_data <= bus.val_in;
            vec_cnt      <= vec_cnt + 1'b1;
            if (vec_cnt == cols - 1'b1)
              state <= NZ_VAL;
          end
        NZ_VAL:
          if (xfer) begin
            if (bus.val_in != '0) begin
              asm_val[slot_cnt] <= bus.val_in;
              asm_ipv[slot_cnt] <= bus.ipv_in;
              if (bus.ipv_in && rows_seen != 8'hff)
                rows_seen <= rows_seen + 1'b1;
              state <= NZ_IDX;
            end else begin
              state <= FLUSH;
            end
          end
        NZ_IDX:
          if (xfer) begin
            asm_val[slot_cnt] <= idx_val;
            asm_col[slot_cnt] <= idx_col;
            if (col_bad)
              bus.err <= 1'b1;
            slot_cnt <= last_slot ? '0 :
                        slot_cnt + 1'b1;
            if (last_slot && !bfree)
              asm_full <= 1'b1;
            state <= NZ_VAL;
          end
        FLUSH:
          if (bfree) begin
            slot_cnt <= '0;
            state    <= DONE;
          end
        DONE:
          if (bus.batch_valid && bus.batch_ready) begin
            bus.frame_done <= 1'b1;
            if (rows_seen != 8'(rows))
              bus.err <= 1'b1;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_smvm_batch_scheduler.sv
// Randomised and directed bench for smvm_batch_scheduler.
module tb_smvm_batch_scheduler;
  localparam int K = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  smvm_batch_scheduler_if #(.K(K), .VW(8)) bus ();
  smvm_batch_scheduler #(.K(K), .VW(8), .MAXC(128)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] val;
    logic [27:0] col;
    logic [3:0]  ipv;
    logic        last;
  } bat_t;

  typedef struct packed {
    logic [7:0] v;
    logic [7:0] c;
    logic       ipv;
  } nz_t;

  int checks = 0;
  int failures = 0;
  int rdy_mode = 1;
  int fd_cnt = 0;
  logic fd_err = 1'b0;
  logic exp_err;
  bat_t got_b[$];
  bat_t exp_b[$];
  logic [14:0] got_v[$];
  logic [7:0] vec_q[$];
  nz_t nz_q[$];

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 2) bus.batch_ready = 1'($urandom_range(0, 1));
    else bus.batch_ready = (rdy_mode == 1);
  end

  always @(negedge clk) begin
    if (bus.vec_we) got_v.push_back({bus.vec_addr, bus.vec_data});
    if (bus.batch_valid && bus.batch_ready)
      got_b.push_back(bat_t'({bus.batch_val, bus.batch_col,
                              bus.batch_ipv, bus.batch_last}));
    if (bus.frame_done) begin
      fd_cnt++;
      fd_err = bus.err;
    end
  end

  function automatic bat_t cur_batch();
    return bat_t'({bus.batch_val, bus.batch_col,
                   bus.batch_ipv, bus.batch_last});
  endfunction

  // Reference: group nonzeros K at a time, always close with a last batch.
  task automatic build_exp(input int rows, input int cols);
    int n;
    int seen;
    n = nz_q.size();
    seen = 0;
    exp_b.delete();
    exp_err = 1'b0;
    for (int b = 0; b <= n / K; b++) begin
      bat_t e;
      e = '0;
      e.last = (b == n / K);
      for (int s = 0; s < K; s++) begin
        if (b * K + s < n) begin
          nz_t z;
          bit ok;
          z = nz_q[b * K + s];
          ok = int'(z.c[6:0]) < cols;
          e.val[(K-1-s)*8 +: 8] = ok ? z.v : 8'd0;
          e.col[(K-1-s)*7 +: 7] = ok ? z.c[6:0] : 7'd0;
          e.ipv[K-1-s] = z.ipv;
          if (!ok) exp_err = 1'b1;
          if (z.ipv && seen < 255) seen++;
        end
      end
      exp_b.push_back(e);
    end
    if (seen != rows) exp_err = 1'b1;
  endtask

  task automatic send(input logic [7:0] v, input logic ipv);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.val_in = v;
    bus.ipv_in = ipv;
    while (!bus.in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout in_ready=%b required=1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input int rows, input int cols);
    send(8'(rows), 1'b0);
    send(8'(cols), 1'b0);
    foreach (vec_q[i]) send(vec_q[i], 1'b0);
    foreach (nz_q[i]) begin
      send(nz_q[i].v, nz_q[i].ipv);
      send(nz_q[i].c, 1'b0);
    end
    send(8'd0, 1'b0);
  endtask

  task automatic wait_done(input int prev);
    int n;
    n = 0;
    while (fd_cnt == prev && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (fd_cnt == prev) begin
      checks++;
      failures++;
      $display("FAIL frame_done_timeout count=%0d required>%0d", fd_cnt, prev);
    end
  endtask

  task automatic clear_obs();
    got_v.delete();
    got_b.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 6;
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    if (bus.vec_we !== 1'b0) begin failures++; $display("FAIL rst_vec_we got=%b exp=0", bus.vec_we); end
    if (bus.batch_valid !== 1'b0) begin failures++; $display("FAIL rst_batch_valid got=%b exp=0", bus.batch_valid); end
    if (bus.batch_last !== 1'b0) begin failures++; $display("FAIL rst_batch_last got=%b exp=0", bus.batch_last); end
    if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL rst_frame_done got=%b exp=0", bus.frame_done); end
    if (bus.err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", bus.err); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_basic();
    int prev;
    logic [7:0] nv[4] = '{8'd5, 8'd6, 8'd7, 8'd8};
    logic [7:0] nc[4] = '{8'd0, 8'd3, 8'd1, 8'd2};
    logic ni[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    bat_t b0;
    rdy_mode = 2;
    clear_obs();
    prev = fd_cnt;
    b0 = bat_t'({32'h05060708, 7'd0, 7'd3, 7'd1, 7'd2, 4'b0101, 1'b0});
    send(8'd2, 1'b0);
    send(8'd4, 1'b0);
    send(8'd1, 1'b0);
    checks++;
    if ({bus.vec_we, bus.vec_addr, bus.vec_data} !== {1'b1, 7'd0, 8'd1}) begin
      failures++;
      $display("FAIL basic_vec_latency got=%b/%0d/%0d exp=1/0/1", bus.vec_we, bus.vec_addr, bus.vec_data);
    end
    for (int i = 2; i <= 4; i++) send(8'(i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(nv[i], ni[i]);
      send(nc[i], 1'b0);
    end
    checks++;
    if (bus.batch_valid !== 1'b1) begin failures++; $display("FAIL basic_batch_latency got=%b exp=1", bus.batch_valid); end
    send(8'd0, 1'b0);
    wait_done(prev);
    checks++;
    if (got_v.size() != 4) begin failures++; $display("FAIL basic_vec_count got=%0d exp=4", got_v.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_v[i] !== {7'(i), 8'(i + 1)}) begin failures++; $display("FAIL basic_vec%0d got=%h exp=%h", i, got_v[i], {7'(i), 8'(i + 1)}); end
    end
    checks++;
    if (got_b.size() != 2) begin failures++; $display("FAIL basic_batch_count got=%0d exp=2", got_b.size()); end
    else begin
      checks += 2;
      if (got_b[0] !== b0) begin failures++; $display("FAIL basic_batch0 got=%h exp=%h", got_b[0], b0); end
      if (got_b[1] !== bat_t'(65'd1)) begin failures++; $display("FAIL basic_pad_batch got=%h exp=%h", got_b[1], bat_t'(65'd1)); end
    end
    checks++;
    if (fd_err !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", fd_err); end
  endtask

  task automatic test_partial();
    int prev;
    bat_t e;
    e = bat_t'({8'd9, 8'd10, 8'd11, 8'd0, 7'd0, 7'd2, 7'd1, 7'd0, 4'b0010, 1'b1});
    clear_obs();
    prev = fd_cnt;
    vec_q = '{8'd1, 8'd2, 8'd3, 8'd4};
    nz_q = '{'{8'd9, 8'd0, 1'b0}, '{8'd10, 8'd2, 1'b0}, '{8'd11, 8'd1, 1'b1}};
    send_frame(1, 4);
    wait_done(prev);
    checks++;
    if (got_b.size() != 1) begin failures++; $display("FAIL partial_count got=%0d exp=1", got_b.size()); end
    else begin
      checks++;
      if (got_b[0] !== e) begin failures++; $display("FAIL partial_batch got=%h exp=%h", got_b[0], e); end
    end
    checks++;
    if (fd_err !== 1'b0) begin failures++; $display("FAIL partial_err got=%b exp=0", fd_err); end
  endtask

  task automatic test_back_to_back();
    int prev;
    bat_t cur;
    rdy_mode = 0;
    clear_obs();
    prev = fd_cnt;
    vec_q = '{8'd7, 8'd9};
    nz_q.delete();
    for (int i = 0; i < 8; i++)
      nz_q.push_back('{8'($urandom_range(1, 255)), 8'($urandom_range(0, 1)), 1'(i == 3 || i == 7)});
    build_exp(2, 2);
    send(8'd2, 1'b0);
    send(8'd2, 1'b0);
    foreach (vec_q[i]) send(vec_q[i], 1'b0);
    foreach (nz_q[i]) begin
      send(nz_q[i].v, nz_q[i].ipv);
      send(nz_q[i].c, 1'b0);
    end
    for (int n = 0; n < 4; n++) begin
      cur = cur_batch();
      checks += 2;
      if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_low cyc=%0d got=%b exp=0", n, bus.in_ready); end
      if (!bus.batch_valid || cur !== exp_b[0]) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/%h", n, bus.batch_valid, cur, exp_b[0]);
      end
      @(negedge clk);
    end
    rdy_mode = 1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_early got=%b exp=0", bus.in_ready); end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready_rise got=%b exp=1", bus.in_ready); end
    send(8'd0, 1'b0);
    wait_done(prev);
    checks++;
    if (got_b.size() != exp_b.size()) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", got_b.size(), exp_b.size()); end
    else foreach (exp_b[i]) begin
      checks++;
      if (got_b[i] !== exp_b[i]) begin failures++; $display("FAIL bp_batch%0d got=%h exp=%h", i, got_b[i], exp_b[i]); end
    end
  endtask

  task automatic test_bad_col();
    int prev;
    bat_t e;
    e = bat_t'({32'd0, 28'd0, 4'b1000, 1'b1});
    rdy_mode = 2;
    clear_obs();
    prev = fd_cnt;
    send(8'd1, 1'b0);
    send(8'd4, 1'b0);
    for (int i = 0; i < 4; i++) send(8'(i + 20), 1'b0);
    send(8'd3, 1'b1);
    send(8'd9, 1'b0);
    checks++;
    if (bus.err !== 1'b1) begin failures++; $display("FAIL badcol_err got=%b exp=1", bus.err); end
    send(8'd0, 1'b0);
    wait_done(prev);
    checks += 2;
    if (got_b.size() != 1 || got_b[0] !== e) begin failures++; $display("FAIL badcol_batch n=%0d exp=%h", got_b.size(), e); end
    if (fd_err !== 1'b1) begin failures++; $display("FAIL badcol_err_done got=%b exp=1", fd_err); end
    send(8'd5, 1'b0);
    checks++;
    if (bus.err !== 1'b0) begin failures++; $display("FAIL hdr_clears_err got=%b exp=0", bus.err); end
    send(8'd0, 1'b0);
    checks += 2;
    if (bus.err !== 1'b1) begin failures++; $display("FAIL cols0_err got=%b exp=1", bus.err); end
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL cols0_idle got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_row_mismatch();
    int prev;
    clear_obs();
    prev = fd_cnt;
    vec_q = '{8'd3, 8'd1, 8'd4, 8'd1};
    nz_q = '{'{8'd2, 8'd1, 1'b0}, '{8'd4, 8'd3, 1'b1},
             '{8'd6, 8'd0, 1'b0}, '{8'd8, 8'd2, 1'b1}, '{8'd1, 8'd1, 1'b0}};
    build_exp(3, 4);
    send_frame(3, 4);
    wait_done(prev);
    checks += 2;
    if (fd_err !== 1'b1) begin failures++; $display("FAIL rows_err got=%b exp=1", fd_err); end
    if (got_b.size() != exp_b.size()) begin failures++; $display("FAIL rows_count got=%0d exp=%0d", got_b.size(), exp_b.size()); end
  endtask

  task automatic test_mid_reset();
    int prev;
    send(8'd2, 1'b0);
    send(8'd4, 1'b0);
    send(8'd10, 1'b0);
    send(8'd20, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    clear_obs();
    rst = 1'b0;
    @(negedge clk);
    checks += 3;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL mrst_in_ready got=%b exp=1", bus.in_ready); end
    if (got_v.size() != 0) begin failures++; $display("FAIL mrst_stale_vec got=%0d exp=0", got_v.size()); end
    if (bus.batch_valid !== 1'b0) begin failures++; $display("FAIL mrst_batch got=%b exp=0", bus.batch_valid); end
    prev = fd_cnt;
    vec_q = '{8'd1, 8'd2, 8'd3, 8'd4};
    nz_q = '{'{8'd5, 8'd0, 1'b0}, '{8'd6, 8'd3, 1'b1}, '{8'd7, 8'd1, 1'b0}, '{8'd8, 8'd2, 1'b1}};
    build_exp(2, 4);
    send_frame(2, 4);
    wait_done(prev);
    checks += 3;
    if (got_v.size() != 4) begin failures++; $display("FAIL mrst_vec_count got=%0d exp=4", got_v.size()); end
    if (got_b.size() != 2 || got_b[0] !== exp_b[0] || got_b[1] !== exp_b[1]) begin
      failures++;
      $display("FAIL mrst_batches n=%0d exp0=%h", got_b.size(), exp_b[0]);
    end
    if (fd_err !== 1'b0) begin failures++; $display("FAIL mrst_err got=%b exp=0", fd_err); end
  endtask

  task automatic test_random();
    rdy_mode = 2;
    for (int f = 0; f < 8; f++) begin
      int prev, cols, nnz, nrow;
      clear_obs();
      prev = fd_cnt;
      cols = $urandom_range(1, 12);
      nnz = $urandom_range(0, 13);
      nrow = 0;
      vec_q.delete();
      nz_q.delete();
      for (int i = 0; i < cols; i++) vec_q.push_back(8'($urandom()));
      for (int i = 0; i < nnz; i++) begin
        nz_t z;
        z.v = 8'($urandom_range(1, 255));
        z.c = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(cols, 255)) : 8'($urandom_range(0, cols - 1));
        z.ipv = 1'($urandom_range(0, 1));
        nrow += int'(z.ipv);
        nz_q.push_back(z);
      end
      if (nrow == 0 || $urandom_range(0, 4) == 0) nrow++;
      build_exp(nrow, cols);
      send_frame(nrow, cols);
      wait_done(prev);
      checks++;
      if (got_v.size() != vec_q.size()) begin failures++; $display("FAIL rnd%0d_vec_count got=%0d exp=%0d", f, got_v.size(), vec_q.size()); end
      else foreach (vec_q[i]) begin
        checks++;
        if (got_v[i] !== {7'(i), vec_q[i]}) begin failures++; $display("FAIL rnd%0d_vec%0d got=%h exp=%h", f, i, got_v[i], {7'(i), vec_q[i]}); end
      end
      checks++;
      if (got_b.size() != exp_b.size()) begin failures++; $display("FAIL rnd%0d_batch_count got=%0d exp=%0d", f, got_b.size(), exp_b.size()); end
      else foreach (exp_b[i]) begin
        checks++;
        if (got_b[i] !== exp_b[i]) begin failures++; $display("FAIL rnd%0d_batch%0d got=%h exp=%h", f, i, got_b[i], exp_b[i]); end
      end
      checks++;
      if (fd_err !== exp_err) begin failures++; $display("FAIL rnd%0d_err got=%b exp=%b", f, fd_err, exp_err); end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.val_in = 8'd0;
    bus.ipv_in = 1'b0;
    bus.batch_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_partial();
    test_back_to_back();
    test_bad_col();
    test_row_mismatch();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
